// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-organised data memory (combinational read, synchronous write).
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses instead of aligning them down.
module load_store_unit #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  state_t      state_q, state_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        bad_req;
  logic        misaligned;
  logic [31:0] byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Misalignment only matters when trapping; otherwise low address bits are simply ignored.
  always_comb begin
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (funct3[1:0] == 2'd2 && addr[1:0] != 2'b00) misaligned = 1'b1;
    if (funct3[1:0] == 2'd1 && addr[0])            misaligned = 1'b1;
`endif
  end

  always_comb begin
    bad_req = 1'b0;
    if (is_load == is_store)                                        bad_req = 1'b1;
    if (is_load && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)) bad_req = 1'b1;
    if (is_store && funct3 > 3'd2)                                  bad_req = 1'b1;
    if ({2'b00, addr[31:2]} >= DEPTH_W)                             bad_req = 1'b1;
    if (misaligned)                                                 bad_req = 1'b1;
  end

  always_comb begin
    byte_lane = mem_rdata >> {addr_q[1:0], 3'b000};
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_lane[7]}}, byte_lane[7:0]};
      3'd1:    load_ext = {{16{half_lane[15]}}, half_lane};
      3'd4:    load_ext = {24'd0, byte_lane[7:0]};
      3'd5:    load_ext = {16'd0, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  // Read-modify-write merge for SB/SH: replace only the addressed lane.
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'd0) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = store_data_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = store_data_q[15:0];
    end else begin
      merged[15:0] = store_data_q[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    merge_d      = merge_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_load_d    = is_load;
          funct3_d     = funct3;
          addr_d       = addr;
          store_data_d = store_data;
          if (bad_req) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (is_load_q) begin
          load_data_d  = load_ext;
          load_valid_d = 1'b1;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else if (funct3_q[1:0] == 2'd2) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          merge_d = merged;
          state_d = WRITE;
        end
      end
      WRITE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      store_data_q <= 32'd0;
      merge_q      <= 32'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      merge_q      <= merge_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Write enable is combinational so a reset in the same cycle suppresses the write.
  assign mem_we = !rst && ((state_q == READ && !is_load_q && funct3_q[1:0] == 2'd2) ||
                           state_q == WRITE);
  assign mem_wdata  = (state_q == WRITE) ? merge_q : store_data_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign req_ready  = (state_q == IDLE);
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random requests against a reference model.
// Expectations follow LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        load_valid;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_ld;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .load_data(load_data), .load_valid(load_valid),
    .done(done), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;

  // ---------------- reference model ----------------
  function automatic bit ref_reject(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit r = 0;
    if (ld == st) r = 1;
    if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) r = 1;
    if (st && f3 > 2) r = 1;
    if ((a >> 2) >= 256) r = 1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3 % 4 == 2 && a % 4 != 0) r = 1;
    if (f3 % 4 == 1 && a % 2 != 0) r = 1;
`endif
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int unsigned boff = a % 4;
    int unsigned hoff = (a / 2) % 2;
    case (f3)
      0, 4: begin
        v = (w >> (8 * boff)) & 32'hFF;
        if (f3 == 0 && v >= 128) v = v - 32'd256;
      end
      1, 5: begin
        v = (w >> (16 * hoff)) & 32'hFFFF;
        if (f3 == 1 && v >= 32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w, input logic [31:0] sd);
    logic [31:0] mask;
    int unsigned sh;
    if (f3 == 0) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
    end else if (f3 == 1) begin
      sh = 16 * ((a / 2) % 2);
      mask = 32'hFFFF << sh;
    end else begin
      return sd;
    end
    return (w & ~mask) | ((sd << sh) & mask);
  endfunction

  // Issue one request and observe it cycle by cycle; cycle k is the k-th cycle after the accept edge.
  task automatic exec(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, output int we_cyc, output int we_cnt, output int done_cyc,
                      output int lv_cyc, output bit err_seen, output bit rdy1,
                      output logic [31:0] ld_val, output logic [31:0] wd);
    we_cyc = 0; we_cnt = 0; done_cyc = 0; lv_cyc = 0; err_seen = 0; rdy1 = 0; ld_val = '0; wd = '0;
    @(negedge clk);
    req_valid = 1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk);
    #1 req_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) rdy1 = req_ready;
      if (mem_we) begin we_cnt++; we_cyc = k; wd = mem_wdata; end
      if (load_valid) lv_cyc = k;
      if (err) err_seen = 1;
      if (done) begin done_cyc = k; ld_val = load_data; break; end
    end
    $display("txn ld=%0b st=%0b f3=%0d addr=%h sd=%h err=%0b done@%0d we@%0d(x%0d) lv@%0d load_data=%h",
             ld, st, f3, a, sd, err_seen, done_cyc, we_cyc, we_cnt, lv_cyc, ld_val);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; req_valid = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we_in_rst got=%b exp=0", mem_we); end
    #1 rst = 0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL reset_load_data got=%h exp=0", load_data); end
    checks++; if ({load_valid, done, err, mem_we} !== 4'b0) begin errors++;
      $display("FAIL reset_pulses got=%b exp=0000", {load_valid, done, err, mem_we}); end
    ref_ld = 0;
  endtask

  task automatic test_loads();
    int wc, wn, dc, lc; bit e, r; logic [31:0] lv, wd;
    exec(1, 0, 3'd0, 32'h13, 0, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (lc !== 2 || dc !== 2) begin errors++; $display("FAIL lb_timing got lv@%0d done@%0d exp 2/2", lc, dc); end
    checks++; if (lv !== 32'hFFFFFF88) begin errors++; $display("FAIL lb_data got=%h exp=ffffff88", lv); end
    checks++; if (wn !== 0 || e) begin errors++; $display("FAIL lb_no_write got we=%0d err=%b exp 0/0", wn, e); end
    exec(1, 0, 3'd5, 32'h12, 0, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (lv !== 32'h00008899) begin errors++; $display("FAIL lhu_data got=%h exp=00008899", lv); end
    exec(1, 0, 3'd4, 32'h10, 0, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (lv !== 32'h000000BB) begin errors++; $display("FAIL lbu_data got=%h exp=000000bb", lv); end
    exec(1, 0, 3'd1, 32'h10, 0, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (lv !== 32'hFFFFAABB) begin errors++; $display("FAIL lh_data got=%h exp=ffffaabb", lv); end
    ref_ld = 32'hFFFFAABB;
  endtask

  task automatic test_misalign();
    int wc, wn, dc, lc; bit e, r; logic [31:0] lv, wd;
    exec(1, 0, 3'd2, 32'h12, 0, wc, wn, dc, lc, e, r, lv, wd);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (!e || dc !== 1 || lc !== 0 || wn !== 0) begin errors++;
      $display("FAIL lw_misalign_err got err=%b done@%0d lv@%0d we=%0d exp 1/1/0/0", e, dc, lc, wn); end
    checks++; if (load_data !== ref_ld) begin errors++; $display("FAIL lw_misalign_hold got=%h exp=%h", load_data, ref_ld); end
`else
    checks++; if (e || lc !== 2 || lv !== 32'h8899AABB) begin errors++;
      $display("FAIL lw_misalign_align got err=%b lv@%0d data=%h exp 0/2/8899aabb", e, lc, lv); end
    ref_ld = 32'h8899AABB;
    exec(1, 0, 3'd5, 32'h13, 0, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (e || lv !== 32'h00008899) begin errors++; $display("FAIL lhu_misalign got err=%b data=%h exp 0/00008899", e, lv); end
    ref_ld = 32'h00008899;
`endif
    exec(1, 0, 3'd2, 32'h400, 0, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (!e || dc !== 1 || r !== 1'b1) begin errors++;
      $display("FAIL lw_range_err got err=%b done@%0d ready=%b exp 1/1/1", e, dc, r); end
    exec(1, 1, 3'd2, 32'h10, 0, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (!e || wn !== 0) begin errors++; $display("FAIL both_op_err got err=%b we=%0d exp 1/0", e, wn); end
    exec(0, 1, 3'd4, 32'h10, 32'hDEAD, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (!e || wn !== 0 || tb_mem[4] !== 32'h8899AABB) begin errors++;
      $display("FAIL store_f3_err got err=%b we=%0d mem=%h exp 1/0/8899aabb", e, wn, tb_mem[4]); end
  endtask

  task automatic test_sb();
    int wc, wn, dc, lc; bit e, r; logic [31:0] lv, wd;
    exec(0, 1, 3'd0, 32'h11, 32'h000000CC, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (wc !== 2 || wn !== 1 || dc !== 3) begin errors++;
      $display("FAIL sb_timing got we@%0d x%0d done@%0d exp 2/1/3", wc, wn, dc); end
    checks++; if (wd !== 32'h8899CCBB) begin errors++; $display("FAIL sb_wdata got=%h exp=8899ccbb", wd); end
    checks++; if (tb_mem[4] !== 32'h8899CCBB) begin errors++; $display("FAIL sb_mem got=%h exp=8899ccbb", tb_mem[4]); end
    ref_mem[4] = 32'h8899CCBB;
  endtask

  task automatic test_sw();
    int wc, wn, dc, lc; bit e, r; logic [31:0] lv, wd;
    exec(0, 1, 3'd2, 32'h10, 32'h12345678, wc, wn, dc, lc, e, r, lv, wd);
    checks++; if (wc !== 1 || wn !== 1 || dc !== 2) begin errors++;
      $display("FAIL sw_timing got we@%0d x%0d done@%0d exp 1/1/2", wc, wn, dc); end
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL sw_busy_ready got=%b exp=0", r); end
    checks++; if (tb_mem[4] !== 32'h12345678) begin errors++; $display("FAIL sw_mem got=%h exp=12345678", tb_mem[4]); end
    ref_mem[4] = 32'h12345678;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1; is_load = 0; is_store = 1; funct3 = 3'd1; addr = 32'h12; store_data = 32'hBEEF;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", req_ready); end
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got=%b exp=0", mem_we); end
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    $display("txn SH 0x12 with reset during WRITE: mem[4]=%h ready=%b", tb_mem[4], req_ready);
    checks++; if (tb_mem[4] !== ref_mem[4]) begin errors++; $display("FAIL rstmid_mem got=%h exp=%h", tb_mem[4], ref_mem[4]); end
    checks++; if (req_ready !== 1'b1 || load_data !== 32'd0) begin errors++;
      $display("FAIL rstmid_state got ready=%b load_data=%h exp 1/0", req_ready, load_data); end
    checks++; if ({load_valid, done, err, mem_we} !== 4'b0) begin errors++;
      $display("FAIL rstmid_pulses got=%b exp=0000", {load_valid, done, err, mem_we}); end
    ref_ld = 0;
  endtask

  task automatic test_random();
    int wc, wn, dc, lc; bit e, r; logic [31:0] lv, wd;
    bit ld, st, x_err; logic [2:0] f3; logic [31:0] a, sd, idx, nw;
    int sel;
    int xd, xw, xl;
    logic [2:0] ld_codes [5];
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 9);
      ld = $urandom_range(0, 1); st = !ld;
      if (sel == 0) st = ld;
      f3 = 3'($urandom_range(0, 7));
      if (sel > 2) f3 = ld ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 1023));
      if (sel == 1) a = $urandom | 32'h400;
      sd = $urandom;
      idx = (a >> 2) % 256;
      x_err = ref_reject(ld, st, f3, a);
      xd = x_err ? 1 : (ld || f3 == 2) ? 2 : 3;
      xw = (x_err || ld) ? 0 : (f3 == 2) ? 1 : 2;
      xl = (!x_err && ld) ? 2 : 0;
      nw = ref_store(f3, a, ref_mem[idx], sd);
      exec(ld, st, f3, a, sd, wc, wn, dc, lc, e, r, lv, wd);
      checks++; if (e !== x_err || dc !== xd || lc !== xl) begin errors++;
        $display("FAIL rnd_ctrl t=%0d got err=%b done@%0d lv@%0d exp %b/%0d/%0d", t, e, dc, lc, x_err, xd, xl); end
      checks++; if (wc !== xw || wn !== (xw != 0 ? 1 : 0)) begin errors++;
        $display("FAIL rnd_we t=%0d got we@%0d x%0d exp we@%0d", t, wc, wn, xw); end
      if (!x_err && ld) ref_ld = ref_load(f3, a, ref_mem[idx]);
      if (!x_err && st) ref_mem[idx] = nw;
      checks++; if (load_data !== ref_ld) begin errors++;
        $display("FAIL rnd_load_data t=%0d got=%h exp=%h", t, load_data, ref_ld); end
      checks++; if (tb_mem[idx] !== ref_mem[idx]) begin errors++;
        $display("FAIL rnd_mem t=%0d idx=%0d got=%h exp=%h", t, idx, tb_mem[idx], ref_mem[idx]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;
    test_reset();
    test_loads();
    test_misalign();
    test_sb();
    test_sw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
